mod_exp_engine: RTL and testbench

- Parametrised, multi-cycle modular exponentiation engine.
- Computes line = message^key mod modulus, where key is the public or the private exponent, selected per operation.
- Replaces the single-cycle power/modulo encoder with a constant-latency square-and-multiply datapath.
- Sits between the key/message source and the serial line driver; one operation is in flight at a time, with a ready/start/valid handshake.

---
 rtl/mod_exp_engine_pkg.sv | 27 ++
 rtl/mod_exp_engine_mod_mult.sv | 79 +++++++
 rtl/mod_exp_engine.sv | 184 ++++++++++++++++++
 tb/tb_mod_exp_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mod_exp_engine_pkg.sv
// ============================================================================
// modexp_pkg: shared states, mode constants and latency helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package modexp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SQUARE = 3'd2,
    MULT   = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic MODE_ENCRYPT = 1'b1;
  localparam logic MODE_DECRYPT = 1'b0;

  // Accept edge to valid_out, for a non-error operation.
  function automatic int modexp_latency(input int width, input int key_width);
    return 2 + 2 * key_width * (width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_exp_engine_mod_mult.sv
// ============================================================================
// mod_mult: r = a*b mod m, MSB-first interleaved shift-add, WIDTH+1 cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mod_mult #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] m_in,
  output logic             done_out,
  output logic [WIDTH-1:0] r_out
);

  localparam int JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH:0]   r_q, r_d, a_q, a_d, m_q, m_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [JW-1:0]    j_q, j_d;
  logic             busy_q, busy_d;
  logic [WIDTH:0]   t;

  always_comb begin
    // One iteration; a<m and r<m keep every intermediate within WIDTH+1 bits.
    t = r_q << 1;
    if (t >= m_q) t = t - m_q;
    if (b_q[j_q]) t = t + a_q;
    if (t >= m_q) t = t - m_q;

    r_d    = r_q;
    a_d    = a_q;
    m_d    = m_q;
    b_d    = b_q;
    j_d    = j_q;
    busy_d = busy_q;
    if (start_in) begin
      r_d    = '0;
      a_d    = {1'b0, a_in};
      m_d    = {1'b0, m_in};
      b_d    = b_in;
      j_d    = JW'(WIDTH - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      r_d = t;
      if (j_q == '0) busy_d = 1'b0;
      else           j_d    = j_q - 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_q    <= '0;
      a_q    <= '0;
      m_q    <= '0;
      b_q    <= '0;
      j_q    <= '0;
      busy_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      a_q    <= a_d;
      m_q    <= m_d;
      b_q    <= b_d;
      j_q    <= j_d;
      busy_q <= busy_d;
    end
  end

  // Final iteration result is presented combinationally alongside done_out.
  assign done_out = busy_q && (j_q == '0);
  assign r_out    = t[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/mod_exp_engine.sv
// ============================================================================
// mod_exp_engine: constant-latency square-and-multiply modular exponentiation.
// Optional macro MODEXP_CYCLE_COUNT_EN adds the cycles_out counter port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mod_exp_engine
  import modexp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int KEY_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 mode_in,
  input  logic [WIDTH-1:0]     message_in,
  input  logic [WIDTH-1:0]     modulus_in,
  input  logic [KEY_WIDTH-1:0] public_key_in,
  input  logic [KEY_WIDTH-1:0] private_key_in,
  output logic                 ready_out,
  output logic                 valid_out,
  output logic                 error_out,
  output logic [WIDTH-1:0]     line_out
`ifdef MODEXP_CYCLE_COUNT_EN
  , output logic [15:0]        cycles_out
`endif
);

  localparam int IW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     msg_q, msg_d, mod_q, mod_d, acc_q, acc_d, line_q, line_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 err_q, err_d, error_q, error_d, valid_q, valid_d;
  logic                 started_q, started_d;
  logic                 mm_start, mm_done;
  logic [WIDTH-1:0]     mm_b, mm_r;
`ifdef MODEXP_CYCLE_COUNT_EN
  logic [15:0]          cnt_q, cnt_d, cycles_q, cycles_d;
`endif

  assign mm_b = (state_q == SQUARE) ? acc_q : msg_q;

  mod_mult #(.WIDTH(WIDTH)) u_mod_mult (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .start_in(mm_start),
    .a_in    (acc_q),
    .b_in    (mm_b),
    .m_in    (mod_q),
    .done_out(mm_done),
    .r_out   (mm_r)
  );

  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    mod_d     = mod_q;
    acc_d     = acc_q;
    key_d     = key_q;
    idx_d     = idx_q;
    err_d     = err_q;
    started_d = started_q;
    line_d    = line_q;
    error_d   = error_q;
    valid_d   = 1'b0;
    mm_start  = 1'b0;
`ifdef MODEXP_CYCLE_COUNT_EN
    cnt_d     = (state_q != IDLE) ? cnt_q + 16'd1 : cnt_q;
    cycles_d  = cycles_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_in) begin
          msg_d   = message_in;
          mod_d   = modulus_in;
          key_d   = (mode_in == MODE_ENCRYPT) ? public_key_in : private_key_in;
          state_d = CHECK;
`ifdef MODEXP_CYCLE_COUNT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      CHECK: begin
        if (mod_q < WIDTH'(2) || msg_q >= mod_q) begin
          err_d   = 1'b1;
          acc_d   = '0;
          state_d = DONE;
        end else begin
          err_d     = 1'b0;
          acc_d     = WIDTH'(1);
          idx_d     = IW'(KEY_WIDTH - 1);
          started_d = 1'b0;
          state_d   = SQUARE;
        end
      end
      SQUARE: begin
        if (!started_q) begin
          mm_start  = 1'b1;
          started_d = 1'b1;
        end else if (mm_done) begin
          acc_d     = mm_r;
          started_d = 1'b0;
          state_d   = MULT;
        end
      end
      MULT: begin
        // Product is always computed so timing does not depend on the key bit.
        if (!started_q) begin
          mm_start  = 1'b1;
          started_d = 1'b1;
        end else if (mm_done) begin
          if (key_q[idx_q]) acc_d = mm_r;
          started_d = 1'b0;
          if (idx_q == '0) state_d = DONE;
          else begin
            idx_d   = idx_q - 1'b1;
            state_d = SQUARE;
          end
        end
      end
      DONE: begin
        valid_d = 1'b1;
        line_d  = acc_q;
        error_d = err_q;
        state_d = IDLE;
`ifdef MODEXP_CYCLE_COUNT_EN
        cycles_d = cnt_q + 16'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      msg_q     <= '0;
      mod_q     <= '0;
      acc_q     <= '0;
      key_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      started_q <= 1'b0;
      line_q    <= '0;
      error_q   <= 1'b0;
      valid_q   <= 1'b0;
`ifdef MODEXP_CYCLE_COUNT_EN
      cnt_q     <= '0;
      cycles_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      msg_q     <= msg_d;
      mod_q     <= mod_d;
      acc_q     <= acc_d;
      key_q     <= key_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      started_q <= started_d;
      line_q    <= line_d;
      error_q   <= error_d;
      valid_q   <= valid_d;
`ifdef MODEXP_CYCLE_COUNT_EN
      cnt_q     <= cnt_d;
      cycles_q  <= cycles_d;
`endif
    end
  end

  assign ready_out = (state_q == IDLE);
  assign valid_out = valid_q;
  assign error_out = error_q;
  assign line_out  = line_q;
`ifdef MODEXP_CYCLE_COUNT_EN
  assign cycles_out = cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_exp_engine.sv
// ============================================================================
// tb_mod_exp_engine: directed and random checks against a modpow model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mod_exp_engine;

  localparam int W   = 8;
  localparam int KW  = 8;
  localparam int LAT = 2 + 2 * KW * (W + 1);

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic          mode_in = 1'b0;
  logic [W-1:0]  message_in = '0, modulus_in = '0;
  logic [KW-1:0] public_key_in = '0, private_key_in = '0;
  logic          ready_out, valid_out, error_out;
  logic [W-1:0]  line_out;
`ifdef MODEXP_CYCLE_COUNT_EN
  logic [15:0]   cycles_out;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  mod_exp_engine #(.WIDTH(W), .KEY_WIDTH(KW)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .mode_in       (mode_in),
    .message_in    (message_in),
    .modulus_in    (modulus_in),
    .public_key_in (public_key_in),
    .private_key_in(private_key_in),
    .ready_out     (ready_out),
    .valid_out     (valid_out),
    .error_out     (error_out),
    .line_out      (line_out)
`ifdef MODEXP_CYCLE_COUNT_EN
    , .cycles_out  (cycles_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Plain repeated multiplication: b^e mod m.
  function automatic int modpow(input int b, input int e, input int m);
    int r = 1 % m;
    for (int k = 0; k < e; k++) r = (r * b) % m;
    return r;
  endfunction

  task automatic drive(input logic mode, input int msg, input int mod, input int pub, input int priv);
    int n = 0;
    @(negedge clk_in);
    while (!ready_out && n < 1000) begin
      @(negedge clk_in);
      n++;
    end
    check("ready_before_start", ready_out, 1);
    mode_in        = mode;
    message_in     = W'(msg);
    modulus_in     = W'(mod);
    public_key_in  = KW'(pub);
    private_key_in = KW'(priv);
    start_in       = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
  endtask

  task automatic run_op(input logic mode, input int msg, input int mod, input int pub, input int priv,
                        output int line, output logic err, output int lat);
    drive(mode, msg, mod, pub, priv);
    lat = 0;
    do begin
      @(posedge clk_in);
      #1;
      lat++;
    end while (!valid_out && lat < 1000);
    if (!valid_out) check("valid_timeout", 0, 1);
    line = int'(line_out);
    err  = error_out;
`ifdef MODEXP_CYCLE_COUNT_EN
    check("cycles_out", cycles_out, (mod < 2 || msg >= mod) ? 2 : LAT);
`endif
  endtask

  // Full legal operation checked against the model, including latency.
  task automatic legal_op(input string tag, input logic mode, input int msg, input int mod,
                          input int pub, input int priv);
    int   line, lat;
    logic err;
    run_op(mode, msg, mod, pub, priv, line, err, lat);
    check({tag, "_line"}, line, modpow(msg, mode ? pub : priv, mod));
    check({tag, "_err"}, err, 0);
    check({tag, "_lat"}, lat, LAT);
  endtask

  initial begin
    int   line, lat, cnt, m, mg;
    logic err;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_ready", ready_out, 1);
    check("rst_valid", valid_out, 0);
    check("rst_error", error_out, 0);
    check("rst_line", line_out, 0);

    run_op(1'b1, 3, 14, 5, 0, line, err, lat);
    check("enc_line", line, 5);
    check("enc_err", err, 0);
    check("enc_lat", lat, LAT);

    run_op(1'b0, 5, 14, 0, 11, line, err, lat);
    check("dec_line", line, 3);
    check("dec_lat", lat, LAT);

    for (int msg = 0; msg < 14; msg++) begin
      int c;
      run_op(1'b1, msg, 14, 5, 11, c, err, lat);
      check("rt_enc", c, modpow(msg, 5, 14));
      run_op(1'b0, c, 14, 5, 11, line, err, lat);
      check("rt_dec", line, msg);
    end

    run_op(1'b1, 14, 14, 5, 11, line, err, lat);
    check("err_msg_line", line, 0);
    check("err_msg_err", err, 1);
    check("err_msg_lat", lat, 2);
    run_op(1'b0, 0, 1, 5, 11, line, err, lat);
    check("err_mod_line", line, 0);
    check("err_mod_err", err, 1);
    check("err_mod_lat", lat, 2);

    legal_op("key0", 1'b1, 9, 14, 0, 11);
    check("key0_const", line_out, 1);
    legal_op("key255", 1'b0, 13, 255, 7, 255);
    legal_op("msg0", 1'b1, 0, 200, 77, 3);

    for (int k = 0; k < 15; k++) begin
      m  = $urandom_range(255, 2);
      mg = $urandom_range(m - 1, 0);
      legal_op("rand", 1'($urandom_range(1, 0)), mg, m, $urandom_range(255, 0), $urandom_range(255, 0));
    end

    // Stray start during SQUARE must be ignored.
    drive(1'b1, 7, 101, 23, 0);
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    cnt = 0;
    repeat (300) begin
      @(posedge clk_in);
      #1;
      if (valid_out) cnt++;
    end
    check("stray_valid_count", cnt, 1);
    check("stray_line", line_out, modpow(7, 23, 101));

    // Reset mid-operation discards the result.
    drive(1'b1, 11, 97, 45, 0);
    repeat (49) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("midrst_ready", ready_out, 1);
    check("midrst_line", line_out, 0);
    check("midrst_valid", valid_out, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    cnt = 0;
    repeat (300) begin
      @(posedge clk_in);
      #1;
      if (valid_out) cnt++;
    end
    check("midrst_no_valid", cnt, 0);

    // Back-to-back: start held high re-accepts right after DONE.
    drive(1'b1, 6, 77, 13, 0);
    start_in = 1'b1;
    lat = 0;
    do begin
      @(posedge clk_in);
      #1;
      lat++;
    end while (!valid_out && lat < 1000);
    check("b2b_first_line", line_out, modpow(6, 13, 77));
    lat = 0;
    do begin
      @(posedge clk_in);
      #1;
      lat++;
    end while (!valid_out && lat < 1000);
    start_in = 1'b0;
    check("b2b_gap", lat, LAT + 1);
    check("b2b_second_line", line_out, modpow(6, 13, 77));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
